delay: RTL and testbench

DELAY -- requirements
Module: delay

---
 rtl/delay.sv | 72 +++++++
 tb/tb_delay.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/delay.sv
// ---------------------------------------------------------------------------
// delay -- fixed-latency pipeline delay line.
//
// Delays an opaque WIDTH-bit data word by exactly DELAY clock cycles. A new
// sample is accepted on every rising clk edge; there is no enable or
// handshake. With DELAY = 0 the block is a plain wire and has no state.
//
// Parameters:
//   WIDTH  data path width in bits (>= 1)
//   DELAY  latency in clock cycles from din to dout (>= 0)
//
// Ports:
//   clk    input   1      clock, rising edge
//   rst_n  input   1      synchronous active-low reset; clears every stage
//   din    input   WIDTH  data in, sampled every rising edge
//   dout   output  WIDTH  din delayed by DELAY cycles, driven straight from
//                         the last stage register
// ---------------------------------------------------------------------------
module delay #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (WIDTH < 1 || DELAY < 0) begin : g_bad_param
        $error("delay: illegal parameters WIDTH=%0d (must be >= 1), DELAY=%0d (must be >= 0)",
               WIDTH, DELAY);
        assign dout = '0;

    end else if (DELAY == 0) begin : g_passthrough
        // Pure wire: clk and rst_n are intentionally unused here.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst_n};
        assign dout        = din;

    end else begin : g_chain
        logic [WIDTH-1:0] stage_q [DELAY];
        logic [WIDTH-1:0] stage_d [DELAY];

        // Next-state of the shift chain: stage 0 takes din, every later stage
        // takes its predecessor.
        always_comb begin
            stage_d[0] = din;
            for (int k = 1; k < DELAY; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end

        // NOTE: the stages form a shift register, so every one must update with
        // <= from the values held before the edge; blocking assignments here
        // would let din ripple through the whole chain in a single cycle.
        // NOTE: clearing the whole chain is what discards in-flight samples on
        // a mid-stream reset. When rst_n is tied high, synthesis drops this
        // branch and the chain can map onto shift-register primitives.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < DELAY; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign dout = stage_q[DELAY-1];
    end

endmodule

// File: tb/tb_delay.sv
// ---------------------------------------------------------------------------
// tb_delay -- directed bench for the delay line.
//
// Five instances cover the parameter points of interest:
//   u_d3 : WIDTH=3,  DELAY=3  counting latency check
//   u_d4 : WIDTH=1,  DELAY=4  single pulse
//   u_d5 : WIDTH=8,  DELAY=5  reset mid-stream
//   u_d0 : WIDTH=16, DELAY=0  combinational passthrough
//   u_d1 : WIDTH=17, DELAY=1  back-to-back random data
// Inputs change on the falling edge; outputs are checked on the falling edge
// just before new inputs are driven, i.e. half a cycle away from the active
// rising edge.
// ---------------------------------------------------------------------------
module tb_delay;

    logic clk;

    logic        rst3, rst4, rst5, rst0, rst1;
    logic [2:0]  din3, dout3;
    logic        din4, dout4;
    logic [7:0]  din5, dout5;
    logic [15:0] din0, dout0;
    logic [16:0] din1, dout1;

    int total;
    int bad;

    delay #(.WIDTH(3),  .DELAY(3)) u_d3 (.clk(clk), .rst_n(rst3), .din(din3), .dout(dout3));
    delay #(.WIDTH(1),  .DELAY(4)) u_d4 (.clk(clk), .rst_n(rst4), .din(din4), .dout(dout4));
    delay #(.WIDTH(8),  .DELAY(5)) u_d5 (.clk(clk), .rst_n(rst5), .din(din5), .dout(dout5));
    delay #(.WIDTH(16), .DELAY(0)) u_d0 (.clk(clk), .rst_n(rst0), .din(din0), .dout(dout0));
    delay #(.WIDTH(17), .DELAY(1)) u_d1 (.clk(clk), .rst_n(rst1), .din(din1), .dout(dout1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All registered instances held in reset for two edges; every stage must
    // then read zero. The passthrough must follow din even during reset.
    task automatic test_reset();
        rst3 = 1'b0; rst4 = 1'b0; rst5 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
        din3 = 3'd7; din4 = 1'b1; din5 = 8'hFF; din0 = 16'h1234; din1 = 17'h1FFFF;
        @(negedge clk);
        @(negedge clk);
        total++; if (dout3 !== 3'd0)    begin bad++; $display("FAIL reset_d3: got %h expected 0", dout3); end
        total++; if (dout4 !== 1'b0)    begin bad++; $display("FAIL reset_d4: got %h expected 0", dout4); end
        total++; if (dout5 !== 8'h00)   begin bad++; $display("FAIL reset_d5: got %h expected 00", dout5); end
        total++; if (dout1 !== 17'h0)   begin bad++; $display("FAIL reset_d1: got %h expected 0", dout1); end
        total++; if (dout0 !== 16'h1234) begin bad++; $display("FAIL reset_d0: got %h expected 1234", dout0); end
        // Leave all inputs at zero so post-reset history is known.
        din3 = '0; din4 = '0; din5 = '0; din1 = '0;
    endtask

    // din counts 0..7 wrapping; dout must be din from three edges earlier,
    // with zeros until the first sample has propagated.
    task automatic test_latency();
        logic [2:0] exp3;
        rst3 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            exp3 = (i >= 3) ? 3'((i - 3) % 8) : 3'd0;
            total++;
            if (dout3 !== exp3) begin
                bad++; $display("FAIL latency_d3 cycle %0d: got %0d expected %0d", i, dout3, exp3);
            end
            din3 = 3'(i % 8);
            @(negedge clk);
        end
    endtask

    // One-cycle pulse must emerge exactly four cycles later, for one cycle.
    task automatic test_pulse();
        logic exp4;
        rst4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp4 = (i == 4);
            total++;
            if (dout4 !== exp4) begin
                bad++; $display("FAIL pulse_d4 cycle %0d: got %0b expected %0b", i, dout4, exp4);
            end
            din4 = (i == 0);
            @(negedge clk);
        end
    endtask

    // Constant 0xA5 stream, then one reset edge: output goes to zero at once,
    // in-flight copies are lost, and 0xA5 returns five edges after release.
    task automatic test_reset_midstream();
        logic [7:0] exp5;
        rst5 = 1'b1;
        din5 = 8'hA5;
        repeat (6) @(negedge clk);
        total++;
        if (dout5 !== 8'hA5) begin
            bad++; $display("FAIL midstream_fill_d5: got %h expected a5", dout5);
        end
        rst5 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            exp5 = (k >= 5) ? 8'hA5 : 8'h00;
            total++;
            if (dout5 !== exp5) begin
                bad++; $display("FAIL midstream_d5 k=%0d: got %h expected %h", k, dout5, exp5);
            end
            rst5 = 1'b1;
            @(negedge clk);
        end
    endtask

    // Passthrough follows din within the same time step, with clk running
    // and rst_n toggled, including right at rising edges.
    task automatic test_passthrough();
        logic [15:0] v;
        for (int i = 0; i < 20; i++) begin
            v    = 16'($urandom());
            rst0 = i[0];
            if (i[1]) @(posedge clk); else #3;
            din0 = v;
            #1;
            total++;
            if (dout0 !== v) begin
                bad++; $display("FAIL passthrough_d0 #%0d: got %h expected %h", i, dout0, v);
            end
        end
        @(negedge clk);
    endtask

    // 1000 random words, one per cycle; scoreboard is simply the previous word.
    task automatic test_back_to_back();
        logic [16:0] prev;
        logic [16:0] v;
        prev = 17'h0;
        rst1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            total++;
            if (dout1 !== prev) begin
                bad++; $display("FAIL back_to_back_d1 #%0d: got %h expected %h", i, dout1, prev);
            end
            v    = 17'($urandom());
            din1 = v;
            prev = v;
            @(negedge clk);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_latency();
        test_pulse();
        test_reset_midstream();
        test_passthrough();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
